// File: rtl/sw_led_pkg.sv
// Shared types and parameter defaults for the switch-driven LED controller.
package sw_led_pkg;

  typedef enum logic [1:0] {
    ModeOff  = 2'd0,
    ModeOn   = 2'd1,
    ModeSlow = 2'd2,
    ModeFast = 2'd3
  } mode_e;

  localparam int unsigned DebCyclesDefault = 500000;
  localparam int unsigned SlowDivDefault   = 25000000;
  localparam int unsigned FastDivDefault   = 6250000;

  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    unique case (cur)
      ModeOff:  nxt = ModeOn;
      ModeOn:   nxt = ModeSlow;
      ModeSlow: nxt = ModeFast;
      default:  nxt = ModeOff;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer, counter debouncer and rising-edge press pulse for a raw switch.
module sw_debounce
  import sw_led_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic sw_raw_i,
  output logic press_o,
  output logic stable_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_d, stable_q;
  logic            stable_prev_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            press_d, press_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    // Registered off the stable level so the pulse lands one cycle after it rises.
    press_d = stable_q & ~stable_prev_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
      press_q       <= 1'b0;
    end else begin
      sync1_q       <= sw_raw_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
    end
  end

  assign press_o  = press_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/sw_led_ctrl.sv
// Switch-stepped mode FSM (OFF/ON/SLOW/FAST) with blink divider and registered LED drive.
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault,
  parameter int unsigned SLOW_DIV   = SlowDivDefault,
  parameter int unsigned FAST_DIV   = FastDivDefault
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SW0,
  output logic       LED0,
  output logic [1:0] MODE
);

  localparam int unsigned BlinkW = $clog2(SLOW_DIV);
  localparam logic [BlinkW-1:0] SlowMax = BlinkW'(SLOW_DIV - 1);
  localparam logic [BlinkW-1:0] FastMax = BlinkW'(FAST_DIV - 1);

  logic              press;
  mode_e             mode_d, mode_q;
  logic [BlinkW-1:0] blink_cnt_d, blink_cnt_q;
  logic [BlinkW-1:0] div_max;
  logic              phase_d, phase_q;
  logic              led_d, led_q;

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sw_debounce (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .sw_raw_i(SW0),
    .press_o (press),
    .stable_o()
  );

  always_comb begin
    mode_d      = mode_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    div_max     = (mode_q == ModeFast) ? FastMax : SlowMax;
    // A mode change wins over a coincident wrap so each blink mode starts lit.
    if (press) begin
      mode_d      = next_mode(mode_q);
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (mode_q == ModeSlow || mode_q == ModeFast) begin
      if (blink_cnt_q == div_max) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end else begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end

    unique case (mode_q)
      ModeOff: led_d = 1'b0;
      ModeOn:  led_d = 1'b1;
      default: led_d = phase_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q      <= ModeOff;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  assign LED0 = led_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Scoreboard bench: stimulus queues expected MODE changes and LED samples by edge number.
module tb_sw_led_ctrl;

  typedef struct {
    int         at;
    logic [1:0] val;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       SW0 = 1'b0;
  logic       LED0;
  logic [1:0] MODE;

  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mode_exp[$];
  exp_t led_exp[$];
  logic [1:0] prev_mode = 2'd0;

  int k, m_at, w_at, z_at, a_at, s_at, r_at;

  sw_led_ctrl #(
    .DEB_CYCLES(4),
    .SLOW_DIV  (8),
    .FAST_DIV  (2)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .SW0  (SW0),
    .LED0 (LED0),
    .MODE (MODE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Monitor: every MODE change must match the next queued expectation exactly.
  always @(negedge CLK) begin
    exp_t e;
    if (MODE !== prev_mode) begin
      checks++;
      if (mode_exp.size() == 0) begin
        errors++;
        $display("FAIL mode_change: got mode=%0d at edge %0d, required no change", MODE, edge_cnt);
      end else begin
        e = mode_exp.pop_front();
        if (e.at != edge_cnt || e.val !== MODE) begin
          errors++;
          $display("FAIL mode_change: got mode=%0d at edge %0d, required mode=%0d at edge %0d",
                   MODE, edge_cnt, e.val, e.at);
        end
      end
    end
    prev_mode = MODE;
    while (led_exp.size() > 0 && led_exp[0].at <= edge_cnt) begin
      e = led_exp.pop_front();
      checks++;
      if (e.at != edge_cnt || LED0 !== e.val[0]) begin
        errors++;
        $display("FAIL led: got %0b at edge %0d, required %0b at edge %0d",
                 LED0, edge_cnt, e.val[0], e.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) tick(1);
  endtask

  task automatic push_mode(input int at, input logic [1:0] v);
    exp_t e;
    e.at = at;
    e.val = v;
    mode_exp.push_back(e);
  endtask

  task automatic push_led(input int at, input logic v);
    exp_t e;
    e.at = at;
    e.val = {1'b0, v};
    led_exp.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    #1 RST_N = 1'b0;
    #1;
    check("reset_mode", int'(MODE), 0);
    check("reset_led", int'(LED0), 0);
    tick(3);
    RST_N = 1'b1;
    tick(3);

    // Clean press: OFF -> ON after DEB_CYCLES+4 edges, release is silent.
    k = edge_cnt;
    SW0 = 1'b1;
    push_mode(k + 8, 2'd1);
    push_led(k + 8, 1'b0);
    push_led(k + 9, 1'b1);
    tick(20);
    SW0 = 1'b0;
    push_led(edge_cnt + 15, 1'b1);
    tick(20);

    // Glitch of 3 cycles: nothing changes.
    k = edge_cnt;
    SW0 = 1'b1;
    push_led(k + 10, 1'b1);
    push_led(k + 15, 1'b1);
    tick(3);
    SW0 = 1'b0;
    tick(20);

    // Bounce then hold: exactly one step, ON -> SLOW.
    for (int i = 0; i < 10; i++) begin
      SW0 = ~SW0;
      tick(1);
    end
    k = edge_cnt;
    SW0 = 1'b1;
    m_at = k + 8;
    push_mode(m_at, 2'd2);
    push_led(m_at + 1, 1'b1);
    push_led(m_at + 8, 1'b1);
    push_led(m_at + 9, 1'b0);
    push_led(m_at + 16, 1'b0);
    push_led(m_at + 17, 1'b1);
    tick(12);
    SW0 = 1'b0;

    // Press landing on the SLOW wrap edge m_at+32: FAST starts lit for 2 cycles.
    wait_until(m_at + 24);
    k = edge_cnt;
    SW0 = 1'b1;
    w_at = k + 8;
    push_mode(w_at, 2'd3);
    push_led(w_at, 1'b0);
    push_led(w_at + 1, 1'b1);
    push_led(w_at + 2, 1'b1);
    push_led(w_at + 3, 1'b0);
    push_led(w_at + 4, 1'b0);
    push_led(w_at + 5, 1'b1);
    tick(12);
    SW0 = 1'b0;
    wait_until(w_at + 25);

    // FAST -> OFF wrap-around.
    k = edge_cnt;
    SW0 = 1'b1;
    z_at = k + 8;
    push_mode(z_at, 2'd0);
    push_led(z_at + 1, 1'b0);
    push_led(z_at + 3, 1'b0);
    tick(12);
    SW0 = 1'b0;
    wait_until(z_at + 16);

    // OFF -> ON, then ON -> SLOW with the switch left held.
    k = edge_cnt;
    SW0 = 1'b1;
    a_at = k + 8;
    push_mode(a_at, 2'd1);
    push_led(a_at + 1, 1'b1);
    tick(12);
    SW0 = 1'b0;
    wait_until(a_at + 16);

    k = edge_cnt;
    SW0 = 1'b1;
    s_at = k + 8;
    push_mode(s_at, 2'd2);
    push_led(s_at + 2, 1'b1);
    wait_until(s_at + 3);

    // Reset mid-blink with the switch held: async clear, then one fresh press.
    push_mode(s_at + 3, 2'd0);
    RST_N = 1'b0;
    #1;
    check("async_reset_mode", int'(MODE), 0);
    check("async_reset_led", int'(LED0), 0);
    tick(3);
    RST_N = 1'b1;
    r_at = edge_cnt;
    push_mode(r_at + 8, 2'd1);
    push_led(r_at + 8, 1'b0);
    push_led(r_at + 9, 1'b1);
    push_led(r_at + 30, 1'b1);
    tick(40);

    check("pending_mode_expectations", mode_exp.size(), 0);
    check("pending_led_expectations", led_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
